imem_fetch_port: RTL and testbench

Parametrised, clocked instruction memory for the 32-bit MIPS core. It replaces the combinational byte-array ROM with three additions:
- a request/response fetch handshake with one-cycle latency and back-pressure;
- a word-write programming port;
- alignment and range fault reporting, plus a flush input for branch redirection.

Storage stays byte-addressed and big-endian, so instruction encodings and PC arithmetic are unchanged.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_bank.sv | 41 ++++
 rtl/imem_fetch_port.sv | 92 +++++++++
 tb/tb_imem_fetch_port.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared fault codes, default NOP encoding and the fetch fault classifier for the instruction memory.
// Pure declarations: no state, no timing.
package imem_pkg;

  localparam int FAULT_W = 2;

  localparam logic [FAULT_W-1:0] FAULT_OK       = 2'b00;
  localparam logic [FAULT_W-1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [FAULT_W-1:0] FAULT_RANGE    = 2'b10;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Misalignment wins over range; the range compare is full-width so high PCs never wrap into memory.
  function automatic logic [FAULT_W-1:0] classify(input logic [31:0] addr,
                                                  input logic [31:0] last_word_addr);
    if (addr[1:0] != 2'b00) begin
      return FAULT_MISALIGN;
    end
    if (addr > last_word_addr) begin
      return FAULT_RANGE;
    end
    return FAULT_OK;
  endfunction

endpackage

// File: rtl/imem_bank.sv
// Big-endian byte-array storage with one registered 4-byte read port and one word write port.
// Read data appears one edge after i_rd_en and holds otherwise; same-edge writes are not seen by the read.
module imem_bank #(
  parameter int  DEPTH_BYTES = 256,
  localparam int WW          = $clog2(DEPTH_BYTES) - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rd_en,
  input  logic [WW-1:0] i_rd_word,
  output logic [31:0]   o_rd_data,
  input  logic          i_wr_en,
  input  logic [WW-1:0] i_wr_word,
  input  logic [31:0]   i_wr_data
);

  logic [7:0]  r_mem [DEPTH_BYTES];
  logic [31:0] r_rd_data;

  // The array is deliberately outside reset so programmed code survives a core reset.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[{i_wr_word, 2'b00}] <= i_wr_data[31:24];
      r_mem[{i_wr_word, 2'b01}] <= i_wr_data[23:16];
      r_mem[{i_wr_word, 2'b10}] <= i_wr_data[15:8];
      r_mem[{i_wr_word, 2'b11}] <= i_wr_data[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= 32'h0000_0000;
    end else if (i_rd_en) begin
      r_rd_data <= {r_mem[{i_rd_word, 2'b00}], r_mem[{i_rd_word, 2'b01}],
                    r_mem[{i_rd_word, 2'b10}], r_mem[{i_rd_word, 2'b11}]};
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction fetch port: valid/ready fetch with one-cycle latency, fault reporting, flush and a word programming port.
// req_ready drops while a response is held without rsp_ready or while flush is high; programming never stalls.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int          DEPTH_BYTES = 256,
  parameter logic [31:0] NOP_WORD    = NOP_WORD_DEFAULT,
  parameter int          CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_instr,
  output logic [FAULT_W-1:0] rsp_fault,
  input  logic               flush,
  input  logic               prog_we,
  input  logic [31:0]        prog_addr,
  input  logic [31:0]        prog_wdata,
  output logic [CNT_W-1:0]   fault_cnt
);

  localparam int          WW             = $clog2(DEPTH_BYTES) - 2;
  localparam logic [31:0] LAST_WORD_ADDR = 32'(DEPTH_BYTES - 4);
  localparam logic [31:0] DEPTH_ADDR     = 32'(DEPTH_BYTES);

  logic               r_vld;
  logic [FAULT_W-1:0] r_fault;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_req_ready;
  logic               w_accept;
  logic [FAULT_W-1:0] w_fault;
  logic               w_rd_en;
  logic               w_wr_en;
  logic [31:0]        w_rd_data;
  logic               w_unused;

  assign w_req_ready = !flush && (!r_vld || rsp_ready);
  assign w_accept    = req_valid && w_req_ready;
  assign w_fault     = classify(req_addr, LAST_WORD_ADDR);
  assign w_rd_en     = w_accept && (w_fault == FAULT_OK);
  assign w_wr_en     = prog_we && (prog_addr < DEPTH_ADDR);
  assign w_unused    = ^prog_addr[1:0];

  imem_bank #(
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .i_rd_en   (w_rd_en),
    .i_rd_word (req_addr[WW+1:2]),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_wr_en),
    .i_wr_word (prog_addr[WW+1:2]),
    .i_wr_data (prog_wdata)
  );

  // Flush outranks everything; otherwise a new accept refills the slot the consumer is draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= 1'b0;
      r_fault <= FAULT_OK;
    end else if (flush) begin
      r_vld   <= 1'b0;
    end else if (w_accept) begin
      r_vld   <= 1'b1;
      r_fault <= w_fault;
    end else if (rsp_ready) begin
      r_vld   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept && (w_fault != FAULT_OK) && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The bank data register only loads on good fetches, so faulted responses substitute the NOP here.
  assign rsp_instr = (r_fault == FAULT_OK) ? w_rd_data : NOP_WORD;
  assign rsp_valid = r_vld;
  assign rsp_fault = r_fault;
  assign fault_cnt = r_cnt;
  assign req_ready = w_req_ready;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Randomised and directed bench for imem_fetch_port against a byte-array reference model.
module tb_imem_fetch_port;

  localparam int          DEPTH = 256;
  localparam int          CW    = 4;
  localparam logic [31:0] NOP   = 32'h0BAD_0BAD;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = 32'h0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_instr;
  logic [1:0]    rsp_fault;
  logic          flush = 1'b0;
  logic          prog_we = 1'b0;
  logic [31:0]   prog_addr = 32'h0;
  logic [31:0]   prog_wdata = 32'h0;
  logic [CW-1:0] fault_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_mem [DEPTH];
  logic        m_vld;
  logic [31:0] m_instr;
  logic [1:0]  m_fault;
  int          m_cnt;

  imem_fetch_port #(
    .DEPTH_BYTES (DEPTH),
    .NOP_WORD    (NOP),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_instr  (rsp_instr),
    .rsp_fault  (rsp_fault),
    .flush      (flush),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .fault_cnt  (fault_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // Advance one clock, updating the reference model from the inputs held across the edge.
  task automatic cycle();
    logic        acc;
    logic [1:0]  f;
    logic [31:0] w;
    int          a;
    acc = !rst && req_valid && !flush && (!m_vld || rsp_ready);
    f = 2'b00;
    w = NOP;
    if (req_addr % 4 != 0) f = 2'b01;
    else if (req_addr > 32'(DEPTH - 4)) f = 2'b10;
    if (acc && f == 2'b00) begin
      a = int'(req_addr);
      w = {m_mem[a], m_mem[a+1], m_mem[a+2], m_mem[a+3]};
    end
    @(posedge clk);
    if (rst) begin
      m_vld = 1'b0; m_instr = 32'h0; m_fault = 2'b00; m_cnt = 0;
    end else if (flush) begin
      m_vld = 1'b0;
    end else if (acc) begin
      m_vld = 1'b1; m_instr = w; m_fault = f;
      if (f != 2'b00 && m_cnt < CMAX) m_cnt++;
    end else if (rsp_ready) begin
      m_vld = 1'b0;
    end
    if (prog_we && prog_addr < 32'(DEPTH)) begin
      a = int'(prog_addr) & ~3;
      m_mem[a]   = prog_wdata[31:24];
      m_mem[a+1] = prog_wdata[23:16];
      m_mem[a+2] = prog_wdata[15:8];
      m_mem[a+3] = prog_wdata[7:0];
    end
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr);
    req_valid = 1'b1; req_addr = addr; rsp_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", rsp_valid); end
    checks++; if (rsp_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", rsp_instr); end
    checks++; if (rsp_fault !== 2'b00) begin errors++; $display("FAIL reset_fault got=%b exp=00", rsp_fault); end
    checks++; if (fault_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", fault_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", req_ready); end
  endtask

  task automatic test_back_to_back();
    prog_we = 1'b1; prog_addr = 32'h0; prog_wdata = 32'h8C02_000E;
    cycle();
    prog_addr = 32'h4; prog_wdata = 32'h4129_0002;
    cycle();
    prog_we = 1'b0;
    req_valid = 1'b1; rsp_ready = 1'b1; req_addr = 32'h0;
    cycle();
    checks++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h8C02_000E || rsp_fault !== 2'b00) begin
      errors++; $display("FAIL b2b_first got=%b/%h/%b exp=1/8c02000e/00", rsp_valid, rsp_instr, rsp_fault); end
    req_addr = 32'h4;
    cycle();
    checks++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h4129_0002 || rsp_fault !== 2'b00) begin
      errors++; $display("FAIL b2b_second got=%b/%h/%b exp=1/41290002/00", rsp_valid, rsp_instr, rsp_fault); end
    req_valid = 1'b0;
    cycle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    fetch(32'h0);
    req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy%0d got=%b exp=0", i, req_ready); end
      cycle();
      checks++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h8C02_000E) begin
        errors++; $display("FAIL bp_hold%0d got=%b/%h exp=1/8c02000e", i, rsp_valid, rsp_instr); end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got=%b exp=1", req_ready); end
    cycle();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h4129_0002) begin
      errors++; $display("FAIL bp_next got=%b/%h exp=1/41290002", rsp_valid, rsp_instr); end
    cycle();
  endtask

  task automatic test_faults();
    fetch(32'h2);
    checks++; if (rsp_instr !== NOP || rsp_fault !== 2'b01) begin
      errors++; $display("FAIL flt_misalign got=%h/%b exp=%h/01", rsp_instr, rsp_fault, NOP); end
    fetch(32'(DEPTH));
    checks++; if (rsp_instr !== NOP || rsp_fault !== 2'b10) begin
      errors++; $display("FAIL flt_range got=%h/%b exp=%h/10", rsp_instr, rsp_fault, NOP); end
    checks++; if (fault_cnt !== 4'd2) begin errors++; $display("FAIL flt_cnt2 got=%0d exp=2", fault_cnt); end
    fetch(32'hFFFF_FFFD);
    checks++; if (rsp_fault !== 2'b01) begin errors++; $display("FAIL flt_high_misalign got=%b exp=01", rsp_fault); end
    fetch(32'(DEPTH - 4));
    checks++; if (rsp_fault !== 2'b00 || rsp_instr !== m_instr) begin
      errors++; $display("FAIL flt_last_word got=%b/%h exp=00/%h", rsp_fault, rsp_instr, m_instr); end
    fetch(32'hFFFF_FFFC);
    checks++; if (rsp_fault !== 2'b10) begin errors++; $display("FAIL flt_high_range got=%b exp=10", rsp_fault); end
    for (int i = 0; i < 16; i++) fetch(32'(DEPTH + 4 * i));
    checks++; if (fault_cnt !== 4'(CMAX) || m_cnt != CMAX) begin
      errors++; $display("FAIL flt_saturate got=%0d exp=%0d", fault_cnt, CMAX); end
    cycle();
  endtask

  task automatic test_flush();
    fetch(32'h4);
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b0; flush = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_rdy got=%b exp=0", req_ready); end
    cycle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_clear got=%b exp=0", rsp_valid); end
    flush = 1'b0;
    cycle();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_instr !== 32'h8C02_000E) begin
      errors++; $display("FAIL flush_retry got=%b/%h exp=1/8c02000e", rsp_valid, rsp_instr); end
    rsp_ready = 1'b1;
    cycle();
  endtask

  task automatic test_rbw();
    prog_we = 1'b1; prog_addr = 32'h8; prog_wdata = 32'h0062_3020;
    fetch(32'h8);
    prog_we = 1'b0;
    checks++; if (rsp_instr !== 32'h0 || rsp_fault !== 2'b00) begin
      errors++; $display("FAIL rbw_old got=%h/%b exp=00000000/00", rsp_instr, rsp_fault); end
    fetch(32'h8);
    checks++; if (rsp_instr !== 32'h0062_3020) begin errors++; $display("FAIL rbw_new got=%h exp=00623020", rsp_instr); end
    cycle();
  endtask

  task automatic test_random();
    int sel;
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      req_valid = ($urandom % 4) != 0;
      rsp_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 10) == 0;
      sel = int'($urandom % 10);
      if (sel < 7)       req_addr = 32'($urandom_range(0, DEPTH / 4 - 1) * 4);
      else if (sel == 7) req_addr = 32'($urandom_range(0, DEPTH - 1)) | 32'h1;
      else if (sel == 8) req_addr = 32'(DEPTH) + 32'($urandom_range(0, 63) * 4);
      else               req_addr = $urandom;
      prog_we = ($urandom % 5) == 0;
      prog_addr = (($urandom % 10) == 0) ? 32'(DEPTH) + ($urandom % 1024)
                                         : 32'($urandom_range(16, DEPTH / 4 - 1) * 4) | ($urandom % 4);
      prog_wdata = $urandom;
      #1;
      checks++; if (req_ready !== (!flush && (!m_vld || rsp_ready))) begin
        errors++; $display("FAIL rnd_rdy%0d got=%b", i, req_ready); end
      cycle();
      checks++; if (rsp_valid !== m_vld || fault_cnt !== 4'(m_cnt)) begin
        errors++; $display("FAIL rnd_state%0d got=%b/%0d exp=%b/%0d", i, rsp_valid, fault_cnt, m_vld, m_cnt); end
      if (m_vld) begin
        checks++; if (rsp_instr !== m_instr || rsp_fault !== m_fault) begin
          errors++; $display("FAIL rnd_rsp%0d got=%h/%b exp=%h/%b", i, rsp_instr, rsp_fault, m_instr, m_fault); end
      end
    end
    req_valid = 1'b0; flush = 1'b0; prog_we = 1'b0; rsp_ready = 1'b1;
    cycle();
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 3; i++) fetch(32'h1 + 32'(4 * i));
    req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b0;
    cycle();
    req_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || fault_cnt !== 4'd3) begin
      errors++; $display("FAIL rstm_setup got=%b/%0d exp=1/3", rsp_valid, fault_cnt); end
    prog_we = 1'b1; prog_addr = 32'hC; prog_wdata = 32'hA5A5_1234;
    #2 rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_instr !== 32'h0 || rsp_fault !== 2'b00 || fault_cnt !== '0) begin
      errors++; $display("FAIL rstm_async got=%b/%h/%b/%0d exp=0/0/00/0", rsp_valid, rsp_instr, rsp_fault, fault_cnt); end
    cycle();
    prog_we = 1'b0; rst = 1'b0;
    fetch(32'h0);
    checks++; if (rsp_instr !== 32'h8C02_000E) begin errors++; $display("FAIL rstm_mem got=%h exp=8c02000e", rsp_instr); end
    fetch(32'hC);
    checks++; if (rsp_instr !== 32'hA5A5_1234 || rsp_instr !== m_instr) begin
      errors++; $display("FAIL rstm_prog got=%h exp=a5a51234", rsp_instr); end
    cycle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_vld = 1'b0; m_instr = 32'h0; m_fault = 2'b00; m_cnt = 0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_faults();
    test_flush();
    test_rbw();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
